ysyx_23060061_mem_arbiter: RTL and testbench

YSYX_23060061_MEM_ARBITER -- requirements
Module: ysyx_23060061_mem_arbiter

---
 rtl/ysyx_23060061_mem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_ysyx_23060061_mem_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060061_mem_arbiter.sv
// Two-master memory arbiter: the IFU and the LSU share one memory port.
// The LSU always wins a simultaneous request. Each transaction walks
// IDLE -> REQ -> RESP and holds the memory port until the owning master
// has accepted its response. A response timeout forces an error reply
// so that a silent memory cannot hang a master forever.
module ysyx_23060061_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,

  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,

  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        reqWen_q, reqWen_d;
  logic [31:0] reqAddr_q, reqAddr_d;
  logic [31:0] reqWdata_q, reqWdata_d;
  logic [3:0]  reqWmask_q, reqWmask_d;
  logic [31:0] respData_q, respData_d;
  logic        respErr_q, respErr_d;
  logic        respPending_q, respPending_d;
  logic [15:0] timeoutCnt_q, timeoutCnt_d;

  logic        grantIfu;
  logic        grantLsu;
  logic        inReq;
  logic        respOut;
  logic        ownerHandshake;
  logic [15:0] timeoutCntInc;

  // Grant decode: only in IDLE and never while reset is held; LSU has priority.
  always_comb begin
    grantIfu = 1'b0;
    grantLsu = 1'b0;
    if (!rst && state_q == IDLE) begin
      grantLsu = lsu_req_valid;
      grantIfu = ifu_req_valid & ~lsu_req_valid;
    end
  end

  assign ifu_req_ready  = grantIfu;
  assign lsu_req_ready  = grantLsu;

  assign inReq          = (state_q == REQ);
  assign respOut        = (state_q == RESP) & respPending_q;
  assign ownerHandshake = respOut & (owner_q ? lsu_resp_ready : ifu_resp_ready);
  assign timeoutCntInc  = timeoutCnt_q + 16'd1;

  // Next-state logic: latch the winner's request, wait for memory, then buffer the reply.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    reqWen_d      = reqWen_q;
    reqAddr_d     = reqAddr_q;
    reqWdata_d    = reqWdata_q;
    reqWmask_d    = reqWmask_q;
    respData_d    = respData_q;
    respErr_d     = respErr_q;
    respPending_d = respPending_q;
    timeoutCnt_d  = timeoutCnt_q;

    case (state_q)
      IDLE: begin
        if (grantLsu) begin
          owner_d    = 1'b1;
          reqWen_d   = lsu_wen;
          reqAddr_d  = lsu_addr;
          reqWdata_d = lsu_wdata;
          reqWmask_d = lsu_wmask;
          state_d    = REQ;
        end else if (grantIfu) begin
          owner_d    = 1'b0;
          reqWen_d   = 1'b0;
          reqAddr_d  = ifu_addr;
          reqWdata_d = 32'd0;
          reqWmask_d = 4'd0;
          state_d    = REQ;
        end
      end

      REQ: begin
        if (mem_req_ready) begin
          timeoutCnt_d = 16'd0;
          state_d      = RESP;
        end
      end

      RESP: begin
        if (!respPending_q) begin
          if (mem_resp_valid) begin
            respData_d    = mem_rdata;
            respErr_d     = mem_err;
            respPending_d = 1'b1;
          end else begin
            timeoutCnt_d = timeoutCntInc;
            if (timeoutCntInc == TimeoutLimit) begin
              respData_d    = 32'd0;
              respErr_d     = 1'b1;
              respPending_d = 1'b1;
            end
          end
        end else if (ownerHandshake) begin
          respPending_d = 1'b0;
          state_d       = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and buffer registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      reqWen_q      <= 1'b0;
      reqAddr_q     <= 32'd0;
      reqWdata_q    <= 32'd0;
      reqWmask_q    <= 4'd0;
      respData_q    <= 32'd0;
      respErr_q     <= 1'b0;
      respPending_q <= 1'b0;
      timeoutCnt_q  <= 16'd0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      reqWen_q      <= reqWen_d;
      reqAddr_q     <= reqAddr_d;
      reqWdata_q    <= reqWdata_d;
      reqWmask_q    <= reqWmask_d;
      respData_q    <= respData_d;
      respErr_q     <= respErr_d;
      respPending_q <= respPending_d;
      timeoutCnt_q  <= timeoutCnt_d;
    end
  end

  // Memory request fields are driven only while a request is outstanding.
  always_comb begin
    mem_req_valid = inReq;
    mem_wen       = inReq ? reqWen_q   : 1'b0;
    mem_addr      = inReq ? reqAddr_q  : 32'd0;
    mem_wdata     = inReq ? reqWdata_q : 32'd0;
    mem_wmask     = inReq ? reqWmask_q : 4'd0;
  end

  // Buffered response is steered to the owning master only.
  always_comb begin
    ifu_resp_valid = respOut & ~owner_q;
    lsu_resp_valid = respOut & owner_q;
    ifu_rdata      = ifu_resp_valid ? respData_q : 32'd0;
    ifu_err        = ifu_resp_valid ? respErr_q  : 1'b0;
    lsu_rdata      = lsu_resp_valid ? respData_q : 32'd0;
    lsu_err        = lsu_resp_valid ? respErr_q  : 1'b0;
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_ysyx_23060061_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter. The stimulus process
// drives each scenario cycle by cycle and pushes the response each master
// should eventually accept; a monitor pops and compares on every
// response handshake.
module tb_ysyx_23060061_mem_arbiter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        busy;

  typedef struct {
    logic        master;
    logic [31:0] rdata;
    logic        err;
    logic        chkData;
  } exp_t;

  exp_t expQ[$];
  int   assertCount = 0;
  int   failCount   = 0;

  ysyx_23060061_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .busy(busy)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Word comparison shared by the stimulus process and the monitor.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Single-bit comparison.
  task automatic checkBit(input string name, input logic actual, input logic expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Record the response a master is expected to accept.
  task automatic pushExp(input logic master, input logic [31:0] rdata, input logic err, input logic chkData);
    exp_t e;
    e.master  = master;
    e.rdata   = rdata;
    e.err     = err;
    e.chkData = chkData;
    expQ.push_back(e);
  endtask

  // Drive both masters' request inputs.
  task automatic applyStimulus(input logic iv, input logic [31:0] ia,
                               input logic lv, input logic lw, input logic [31:0] la,
                               input logic [31:0] ld, input logic [3:0] lm);
    ifu_req_valid = iv;
    ifu_addr      = ia;
    lsu_req_valid = lv;
    lsu_wen       = lw;
    lsu_addr      = la;
    lsu_wdata     = ld;
    lsu_wmask     = lm;
  endtask

  // Monitor: compare every response handshake against the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic        gotMaster;
    logic [31:0] gotData;
    logic        gotErr;
    if (!rst) begin
      if (ifu_resp_valid && lsu_resp_valid) begin
        checkBit("mon_both_resp_valid", 1'b1, 1'b0);
      end
      if ((ifu_resp_valid && ifu_resp_ready) || (lsu_resp_valid && lsu_resp_ready)) begin
        gotMaster = lsu_resp_valid;
        gotData   = lsu_resp_valid ? lsu_rdata : ifu_rdata;
        gotErr    = lsu_resp_valid ? lsu_err : ifu_err;
        if (expQ.size() == 0) begin
          checkBit("mon_unexpected_resp", 1'b1, 1'b0);
        end else begin
          e = expQ.pop_front();
          checkBit("mon_resp_master", gotMaster, e.master);
          if (e.chkData) checkOutput("mon_resp_rdata", gotData, e.rdata);
          checkBit("mon_resp_err", gotErr, e.err);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    rst            = 1'b1;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'd0;
    mem_err        = 1'b0;
    ifu_resp_ready = 1'b1;
    lsu_resp_ready = 1'b1;
    applyStimulus(1'b1, 32'h8000_0000, 1'b1, 1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF);
    #2;
    checkBit("rst_ifu_req_ready", ifu_req_ready, 1'b0);
    checkBit("rst_lsu_req_ready", lsu_req_ready, 1'b0);
    checkBit("rst_busy", busy, 1'b0);
    checkBit("rst_mem_req_valid", mem_req_valid, 1'b0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkBit("rst_ifu_resp_valid", ifu_resp_valid, 1'b0);
    checkBit("rst_lsu_resp_valid", lsu_resp_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    cycle();

    $display("[TB] IFU alone, minimum latency");
    applyStimulus(1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    checkBit("s1_c0_ifu_req_ready", ifu_req_ready, 1'b1);
    checkBit("s1_c0_lsu_req_ready", lsu_req_ready, 1'b0);
    pushExp(1'b0, 32'h0000_0413, 1'b0, 1'b1);
    cycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    mem_req_ready = 1'b1;
    #1;
    checkBit("s1_c1_mem_req_valid", mem_req_valid, 1'b1);
    checkOutput("s1_c1_mem_addr", mem_addr, 32'h8000_0000);
    checkBit("s1_c1_mem_wen", mem_wen, 1'b0);
    checkBit("s1_c1_busy", busy, 1'b1);
    cycle();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h0000_0413;
    mem_err        = 1'b0;
    #1;
    checkBit("s1_c2_mem_req_valid", mem_req_valid, 1'b0);
    checkOutput("s1_c2_mem_addr", mem_addr, 32'd0);
    checkBit("s1_c2_ifu_resp_valid", ifu_resp_valid, 1'b0);
    cycle();
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'hFFFF_FFFF;
    #1;
    checkBit("s1_c3_ifu_resp_valid", ifu_resp_valid, 1'b1);
    checkBit("s1_c3_lsu_resp_valid", lsu_resp_valid, 1'b0);
    checkOutput("s1_c3_ifu_rdata", ifu_rdata, 32'h0000_0413);
    cycle();
    #1;
    checkBit("s1_c4_busy", busy, 1'b0);
    checkBit("s1_c4_ifu_resp_valid", ifu_resp_valid, 1'b0);

    $display("[TB] simultaneous requests, LSU write wins");
    applyStimulus(1'b1, 32'h8000_0004, 1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF);
    #1;
    checkBit("s2_c0_lsu_req_ready", lsu_req_ready, 1'b1);
    checkBit("s2_c0_ifu_req_ready", ifu_req_ready, 1'b0);
    pushExp(1'b1, 32'd0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b1, 32'h8000_0004, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    mem_req_ready = 1'b1;
    #1;
    checkBit("s2_c1_mem_wen", mem_wen, 1'b1);
    checkOutput("s2_c1_mem_addr", mem_addr, 32'h8000_1000);
    checkOutput("s2_c1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    checkOutput("s2_c1_mem_wmask", {28'd0, mem_wmask}, 32'h0000_000F);
    checkBit("s2_c1_ifu_req_ready", ifu_req_ready, 1'b0);
    cycle();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h0BAD_F00D;
    mem_err        = 1'b0;
    #1;
    checkBit("s2_c2_ifu_req_ready", ifu_req_ready, 1'b0);
    cycle();
    mem_resp_valid = 1'b0;
    #1;
    checkBit("s2_c3_lsu_resp_valid", lsu_resp_valid, 1'b1);
    checkBit("s2_c3_ifu_resp_valid", ifu_resp_valid, 1'b0);
    checkBit("s2_c3_ifu_req_ready", ifu_req_ready, 1'b0);
    cycle();
    #1;
    checkBit("s2_c4_ifu_req_ready", ifu_req_ready, 1'b1);
    pushExp(1'b0, 32'h1234_5678, 1'b1, 1'b1);
    cycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    mem_req_ready = 1'b1;
    #1;
    checkOutput("s2_c5_mem_addr", mem_addr, 32'h8000_0004);
    checkBit("s2_c5_mem_wen", mem_wen, 1'b0);
    checkOutput("s2_c5_mem_wdata", mem_wdata, 32'd0);
    checkOutput("s2_c5_mem_wmask", {28'd0, mem_wmask}, 32'd0);
    cycle();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h1234_5678;
    mem_err        = 1'b1;
    cycle();
    mem_resp_valid = 1'b0;
    mem_err        = 1'b0;
    #1;
    checkBit("s2_c7_ifu_resp_valid", ifu_resp_valid, 1'b1);
    checkBit("s2_c7_ifu_err", ifu_err, 1'b1);
    cycle();
    #1;
    checkBit("s2_c8_busy", busy, 1'b0);

    $display("[TB] memory stalls request for five cycles");
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h8000_2000, 32'hA5A5_A5A5, 4'h3);
    #1;
    checkBit("s3_c0_lsu_req_ready", lsu_req_ready, 1'b1);
    pushExp(1'b1, 32'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      cycle();
      applyStimulus(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0040, 32'hFFFF_FFFF, 4'hC);
      mem_req_ready = (k == 6);
      #1;
      checkBit("s3_hold_mem_req_valid", mem_req_valid, 1'b1);
      checkOutput("s3_hold_mem_addr", mem_addr, 32'h8000_2000);
      checkOutput("s3_hold_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
      checkOutput("s3_hold_mem_wmask", {28'd0, mem_wmask}, 32'h0000_0003);
      checkBit("s3_hold_mem_wen", mem_wen, 1'b1);
      checkBit("s3_hold_busy", busy, 1'b1);
    end
    cycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_err        = 1'b0;
    cycle();
    mem_resp_valid = 1'b0;
    #1;
    checkBit("s3_resp_lsu_resp_valid", lsu_resp_valid, 1'b1);
    cycle();
    #1;
    checkBit("s3_done_busy", busy, 1'b0);

    $display("[TB] silent memory forces timeout error");
    applyStimulus(1'b1, 32'h8000_3000, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    pushExp(1'b0, 32'd0, 1'b1, 1'b1);
    cycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    mem_req_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      cycle();
      mem_req_ready = 1'b0;
      #1;
      checkBit("s4_wait_ifu_resp_valid", ifu_resp_valid, 1'b0);
    end
    cycle();
    ifu_resp_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h0000_0BAD;
    mem_err        = 1'b0;
    #1;
    checkBit("s4_to_ifu_resp_valid", ifu_resp_valid, 1'b1);
    checkOutput("s4_to_ifu_rdata", ifu_rdata, 32'd0);
    checkBit("s4_to_ifu_err", ifu_err, 1'b1);
    cycle();
    mem_resp_valid = 1'b0;
    ifu_resp_ready = 1'b1;
    #1;
    checkOutput("s4_late_ifu_rdata", ifu_rdata, 32'd0);
    checkBit("s4_late_ifu_err", ifu_err, 1'b1);
    cycle();
    #1;
    checkBit("s4_done_busy", busy, 1'b0);

    $display("[TB] memory reply on the timeout cycle wins");
    applyStimulus(1'b1, 32'h8000_3004, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    pushExp(1'b0, 32'hCAFE_F00D, 1'b0, 1'b1);
    cycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    mem_req_ready = 1'b1;
    cycle();
    mem_req_ready = 1'b0;
    repeat (2) cycle();
    cycle();
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hCAFE_F00D;
    mem_err        = 1'b0;
    cycle();
    mem_resp_valid = 1'b0;
    #1;
    checkBit("s4b_ifu_resp_valid", ifu_resp_valid, 1'b1);
    checkOutput("s4b_ifu_rdata", ifu_rdata, 32'hCAFE_F00D);
    checkBit("s4b_ifu_err", ifu_err, 1'b0);
    cycle();
    #1;
    checkBit("s4b_done_busy", busy, 1'b0);

    $display("[TB] LSU holds off its response for three cycles");
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h8000_4000, 32'd0, 4'd0);
    lsu_resp_ready = 1'b0;
    pushExp(1'b1, 32'h1122_3344, 1'b0, 1'b1);
    cycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    mem_req_ready = 1'b1;
    cycle();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h1122_3344;
    for (int k = 3; k <= 6; k++) begin
      cycle();
      mem_resp_valid = 1'b0;
      mem_rdata      = 32'hFFFF_FFFF;
      lsu_resp_ready = (k == 6);
      #1;
      checkBit("s5_hold_lsu_resp_valid", lsu_resp_valid, 1'b1);
      checkOutput("s5_hold_lsu_rdata", lsu_rdata, 32'h1122_3344);
      checkBit("s5_hold_busy", busy, 1'b1);
    end
    cycle();
    #1;
    checkBit("s5_done_busy", busy, 1'b0);
    checkBit("s5_done_lsu_resp_valid", lsu_resp_valid, 1'b0);

    $display("[TB] reset pulsed during RESP");
    applyStimulus(1'b1, 32'h8000_5000, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    cycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    mem_req_ready = 1'b1;
    cycle();
    mem_req_ready = 1'b0;
    #2;
    rst = 1'b1;
    applyStimulus(1'b1, 32'h8000_6000, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    checkBit("s6_rst_busy", busy, 1'b0);
    checkBit("s6_rst_ifu_req_ready", ifu_req_ready, 1'b0);
    checkBit("s6_rst_ifu_resp_valid", ifu_resp_valid, 1'b0);
    checkBit("s6_rst_mem_req_valid", mem_req_valid, 1'b0);
    cycle();
    rst = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h0000_0BAD;
    mem_err        = 1'b1;
    #1;
    checkBit("s6_late_busy", busy, 1'b0);
    cycle();
    mem_resp_valid = 1'b0;
    mem_err        = 1'b0;
    #1;
    checkBit("s6_late_ifu_resp_valid", ifu_resp_valid, 1'b0);
    checkBit("s6_late_busy2", busy, 1'b0);
    applyStimulus(1'b1, 32'h8000_6000, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    checkBit("s6_fresh_ifu_req_ready", ifu_req_ready, 1'b1);
    pushExp(1'b0, 32'h0010_0073, 1'b0, 1'b1);
    cycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    mem_req_ready = 1'b1;
    #1;
    checkOutput("s6_fresh_mem_addr", mem_addr, 32'h8000_6000);
    cycle();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h0010_0073;
    cycle();
    mem_resp_valid = 1'b0;
    #1;
    checkBit("s6_fresh_ifu_resp_valid", ifu_resp_valid, 1'b1);
    repeat (2) cycle();

    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
